// File: rtl/reset_seq_ctrl.sv
// Staged reset-release controller: releases per-subsystem active-low resets in index order,
// with a hold delay before and an ack wait after each. Ack timeout enabled by RESET_SEQ_TIMEOUT_EN.
module reset_seq_ctrl #(
   parameter bit SIMULATION  = 1'b0,
   parameter int N_STAGES    = 4,
   parameter int STAGE_DELAY = 10000,
   parameter int ACK_TIMEOUT = 50000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_rst,
   input  logic [N_STAGES-1:0]         stage_ack,
   output logic [N_STAGES-1:0]         rst_out_n,
   output logic [$clog2(N_STAGES)-1:0] stage_idx,
   output logic                        seq_done,
   output logic                        seq_fault
);

   localparam int HOLD_CYC = SIMULATION ? 10 : STAGE_DELAY;
   localparam int TO_CYC   = SIMULATION ? 20 : ACK_TIMEOUT;
   localparam int CNT_MAX  = (HOLD_CYC > TO_CYC) ? HOLD_CYC : TO_CYC;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int IDX_W    = $clog2(N_STAGES);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
`endif

   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT_ACK,
      S_DONE
`ifdef RESET_SEQ_TIMEOUT_EN
      , S_FAULT
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   // First cycle out of reset only arms the counter, so stage 0 releases on edge HOLD_CYC
   // counted from the first edge that samples reset low.
   logic             armed;

   // NOTE: all state here is updated with non-blocking assignments so every branch sees
   // the pre-edge values; a blocking write would leak a new value into later reads.
   always_ff @(posedge clk) begin
      if (rst || req_rst) begin
         state     <= S_HOLD;
         cnt       <= '0;
         armed     <= 1'b0;
         stage_idx <= '0;
         rst_out_n <= '0;
         seq_done  <= 1'b0;
         seq_fault <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            S_HOLD: begin
               if (armed) begin
                  if (cnt == HOLD_LAST) begin
                     rst_out_n[stage_idx] <= 1'b1;
                     cnt                  <= '0;
                     state                <= S_WAIT_ACK;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            S_WAIT_ACK: begin
               // Only the current stage's ack matters; a same-cycle ack beats the timeout.
               if (stage_ack[stage_idx]) begin
                  cnt <= '0;
                  if (stage_idx == LAST_IDX) begin
                     seq_done <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     stage_idx <= stage_idx + IDX_W'(1);
                     state     <= S_HOLD;
                  end
               end
`ifdef RESET_SEQ_TIMEOUT_EN
               else if (cnt == TO_LAST) begin
                  cnt       <= '0;
                  rst_out_n <= '0;
                  seq_fault <= 1'b1;
                  state     <= S_FAULT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end

            S_DONE: begin
               rst_out_n <= '1;
               seq_done  <= 1'b1;
            end

`ifdef RESET_SEQ_TIMEOUT_EN
            S_FAULT: begin
               rst_out_n <= '0;
               seq_fault <= 1'b1;
            end
`endif

            default: begin
               state <= S_HOLD;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl (SIMULATION=1, N_STAGES=4): expected output changes are
// queued with their edge number, and a negedge monitor matches every observed change against them.
module tb_reset_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_rst;
   logic [3:0] stage_ack;
   logic [3:0] rst_out_n;
   logic [1:0] stage_idx;
   logic       seq_done;
   logic       seq_fault;

   reset_seq_ctrl #(
      .SIMULATION (1'b1),
      .N_STAGES   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_rst   (req_rst),
      .stage_ack (stage_ack),
      .rst_out_n (rst_out_n),
      .stage_idx (stage_idx),
      .seq_done  (seq_done),
      .seq_fault (seq_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] rst_out_n;
      logic [1:0] idx;
      logic       done;
      logic       fault;
   } obs_t;

   typedef struct {
      int   edge_at;
      obs_t val;
   } ev_t;

   ev_t  exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   edge_no     = 0;
   int   base        = 0;
   bit   mon_en      = 1'b0;
   obs_t cur;
   obs_t prev;
   ev_t  mon_ev;

   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   // Monitor: every change of the observed outputs must be the next queued event.
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {rst_out_n, stage_idx, seq_done, seq_fault};
         if (cur !== prev) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_change: got %h expected %h (edge %0d)", cur, prev, edge_no);
            end else begin
               mon_ev = exp_q.pop_front();
               check("event_edge", edge_no, mon_ev.edge_at);
               check("event_value", 32'(cur), 32'(mon_ev.val));
            end
            prev = cur;
         end
      end
   end

   task automatic push(input int rel, input logic [3:0] r, input int idx, input logic d,
                       input logic f);
      ev_t e;
      e.edge_at = base + rel;
      e.val     = {r, 2'(idx), d, f};
      exp_q.push_back(e);
   endtask

   // Stage k0 enters HOLD after edge t0: release at t0+10, ack seen at t0+11, and so on.
   task automatic push_from(input int k0, input int t0, input int stop);
      int         t;
      logic [3:0] m;
      t = t0;
      for (int k = k0; k < 4; k++) begin
         m = 4'((1 << (k + 1)) - 1);
         if (t + 10 < stop) push(t + 10, m, k, 1'b0, 1'b0);
         if (t + 11 < stop) begin
            if (k == 3) push(t + 11, 4'hF, 3, 1'b1, 1'b0);
            else        push(t + 11, m, k + 1, 1'b0, 1'b0);
         end
         t += 11;
      end
   endtask

   task automatic wait_rel(input int rel);
      while (edge_no < base + rel) @(negedge clk);
   endtask

   task automatic drain(input int limit_rel);
      while (exp_q.size() != 0 && edge_no < base + limit_rel) @(negedge clk);
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL missing_events: got %0d pending expected 0 (edge %0d)", exp_q.size(), edge_no);
         exp_q.delete();
      end
   endtask

   // One-cycle reset pulse driven at a negedge; outputs must clear on the sampling edge.
   task automatic pulse_reset(input logic r, input logic q);
      ev_t e;
      rst       = r;
      req_rst   = q;
      e.edge_at = edge_no + 1;
      e.val     = '0;
      exp_q.push_back(e);
      @(negedge clk);
      rst     = 1'b0;
      req_rst = 1'b0;
      base    = edge_no + 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      req_rst   = 1'b0;
      stage_ack = 4'hF;
      repeat (3) @(negedge clk);
      check("reset_state", 32'({rst_out_n, stage_idx, seq_done, seq_fault}), 32'h0);
      prev   = '0;
      mon_en = 1'b1;
      rst    = 1'b0;
      base   = edge_no + 1;

      // Acks tied high: releases at 10/21/32/43, done one edge after the last release.
      push_from(0, 0, 999);
      drain(60);

      // Ack drops in DONE are ignored.
      wait_rel(50);
      stage_ack = 4'h0;
      wait_rel(56);
      stage_ack = 4'hF;
      wait_rel(58);
      check("done_hold", 32'({rst_out_n, seq_done}), 32'h1F);

      // req_rst in DONE, then again mid-HOLD of stage 2; each replays from cycle 0.
      pulse_reset(1'b0, 1'b1);
      push_from(0, 0, 27);
      wait_rel(26);
      pulse_reset(1'b0, 1'b1);
      push_from(0, 0, 999);
      drain(60);

      // rst and req_rst together; ack[1] first sampled at edge 26.
      stage_ack = 4'b1101;
      wait_rel(50);
      pulse_reset(1'b1, 1'b1);
      push(10, 4'b0001, 0, 1'b0, 1'b0);
      push(11, 4'b0001, 1, 1'b0, 1'b0);
      push(21, 4'b0011, 1, 1'b0, 1'b0);
      push(26, 4'b0011, 2, 1'b0, 1'b0);
      push_from(2, 26, 999);
      wait_rel(25);
      stage_ack = 4'hF;
      drain(60);

`ifndef RESET_SEQ_TIMEOUT_EN
      // Without timeout, a missing ack[0] stalls indefinitely, then resumes normally.
      stage_ack = 4'h0;
      pulse_reset(1'b1, 1'b0);
      push(10, 4'b0001, 0, 1'b0, 1'b0);
      wait_rel(1009);
      check("no_timeout_hold", 32'({rst_out_n, seq_fault}), 32'b00010);
      stage_ack = 4'hF;
      push(1010, 4'b0001, 1, 1'b0, 1'b0);
      push_from(1, 1010, 999);
      drain(1060);
`else
      // ack[2] never arrives: fault 20 edges after its release, stage_idx frozen at 2.
      stage_ack = 4'b1011;
      pulse_reset(1'b0, 1'b1);
      push_from(0, 0, 33);
      push(52, 4'b0000, 2, 1'b0, 1'b1);
      drain(60);
      wait_rel(80);
      check("fault_hold", 32'({rst_out_n, stage_idx, seq_done, seq_fault}), 32'({4'h0, 2'd2, 1'b0, 1'b1}));

      // ack[2] first sampled on the timeout edge: the ack wins.
      pulse_reset(1'b0, 1'b1);
      push_from(0, 0, 33);
      push(52, 4'b0111, 3, 1'b0, 1'b0);
      push_from(3, 52, 999);
      wait_rel(51);
      stage_ack = 4'hF;
      drain(80);
`endif

      wait_rel(90);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
